// File: rtl/mword_add_arbiter.sv
// Two-requester arbiter sharing one ripple adder for multi-word (LS word first) additions.
// Optional MWORD_ADD_ARBITER_SUB_EN adds per-requester reqN_sub for two's-complement subtraction.
module mword_add_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_last,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_last,
`ifdef MWORD_ADD_ARBITER_SUB_EN
    input  logic             req0_sub,
    input  logic             req1_sub,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic             rsp_last
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state, state_nxt;
    logic             owner, ptr, carry_q;
    logic             slot_open, sel, accept, sel_last;
    logic             sub_eff, cin, cout;
    logic [WIDTH-1:0] op_a, op_b, b_eff, sum;

    assign slot_open = !rsp_valid || rsp_ready;

    // A locked transaction keeps the owner; otherwise a lone valid wins and ties go to ptr.
    always_comb begin
        sel = ptr;
        if (state == LOCKED)               sel = owner;
        else if (req0_valid && !req1_valid) sel = 1'b0;
        else if (req1_valid && !req0_valid) sel = 1'b1;
    end

    assign req0_ready = rst_n && slot_open && !sel && (state == LOCKED || req0_valid);
    assign req1_ready = rst_n && slot_open &&  sel && (state == LOCKED || req1_valid);
    assign accept     = sel ? (req1_valid && req1_ready) : (req0_valid && req0_ready);

    assign op_a     = sel ? req1_a    : req0_a;
    assign op_b     = sel ? req1_b    : req0_b;
    assign sel_last = sel ? req1_last : req0_last;

`ifdef MWORD_ADD_ARBITER_SUB_EN
    logic sub_q;

    // The operation is fixed by the first word and held until the last.
    assign sub_eff = (state == IDLE) ? (sel ? req1_sub : req0_sub) : sub_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         sub_q <= 1'b0;
        else if (accept && state == IDLE)   sub_q <= sub_eff;
    end
`else
    assign sub_eff = 1'b0;
`endif

    assign b_eff = op_b ^ {WIDTH{sub_eff}};
    assign cin   = (state == IDLE) ? sub_eff : carry_q;

    always_comb begin
        logic cy;
        sum = '0;
        cy  = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = op_a[i] ^ b_eff[i] ^ cy;
            cy     = (op_a[i] & b_eff[i]) | (cy & (op_a[i] ^ b_eff[i]));
        end
        cout = cy;
    end

    always_comb begin
        state_nxt = state;
        if (accept) state_nxt = sel_last ? IDLE : LOCKED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            ptr       <= 1'b0;
            carry_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner     <= sel;
                carry_q   <= cout;
                rsp_valid <= 1'b1;
                rsp_sum   <= sum;
                rsp_cout  <= cout;
                rsp_id    <= sel;
                rsp_last  <= sel_last;
                if (sel_last) ptr <= ~sel;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mword_add_arbiter.sv
// Scoreboard bench for mword_add_arbiter: directed and random multi-word transactions
// checked against whole-integer arithmetic and an owner/turn arbitration model.
module tb_mword_add_arbiter;
    localparam int W = 4;

    typedef struct {
        int     nw;
        longint a;
        longint b;
        bit     sub;
    } txn_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_last  = '0;
    logic [W-1:0] req_a [2];
    logic [W-1:0] req_b [2];
    logic         ready0, ready1;
    logic         rsp_valid, rsp_ready = 1'b0;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout, rsp_id, rsp_last;
`ifdef MWORD_ADD_ARBITER_SUB_EN
    logic [1:0]   req_sub = '0;
`endif

    mword_add_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_valid[0]), .req0_ready(ready0), .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_last(req_last[0]),
        .req1_valid(req_valid[1]), .req1_ready(ready1), .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_last(req_last[1]),
`ifdef MWORD_ADD_ARBITER_SUB_EN
        .req0_sub(req_sub[0]), .req1_sub(req_sub[1]),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_id(rsp_id), .rsp_last(rsp_last)
    );

    always #5 clk = ~clk;

    int   n_tests = 0, n_fail = 0;
    txn_t tq [2][$];
    txn_t cur [2];
    bit   has [2] = '{0, 0};
    int   widx [2] = '{0, 0};
    bit [1:0] acc = '0;
    exp_t sbq [$];
    bit   gen_en = 0, gap_en = 0;
    int   rdy_mode = 2;
    int   lock = -1, turn = 0;
    bit   m_rv = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic txn_t mk(int nw, longint a, longint b, bit sub);
        txn_t t;
        t.nw = nw; t.a = a; t.b = b; t.sub = sub;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        int     nw  = $urandom_range(1, 4);
        longint msk = (longint'(1) << (W * nw)) - 1;
        bit     sub = 1'b0;
`ifdef MWORD_ADD_ARBITER_SUB_EN
        sub = 1'($urandom);
`endif
        return mk(nw, longint'($urandom) & msk, longint'($urandom) & msk, sub);
    endfunction

    // Word k of the transaction equals word k of the whole-integer result over its low k+1 words.
    function automatic exp_t exp_word(txn_t t, int k);
        exp_t   e;
        longint m    = longint'(1) << (W * (k + 1));
        longint am   = t.a % m;
        longint bm   = t.b % m;
        longint full = t.sub ? (am - bm + m) : (am + bm);
        e.sum  = W'(full >> (W * k));
        e.cout = (full >= m);
        e.id   = 1'b0;
        e.last = 1'b0;
        return e;
    endfunction

    // Driver: advances each requester's word on acceptance, presents the next word.
    initial begin
        req_a = '{default: '0};
        req_b = '{default: '0};
        forever begin
            @(posedge clk); #1;
            rsp_ready = (rdy_mode == 2) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : ($urandom % 4 != 0);
            for (int r = 0; r < 2; r++) begin
                if (!rst_n) begin
                    has[r] = 0; widx[r] = 0;
                end else begin
                    if (acc[r]) begin
                        widx[r]++;
                        if (widx[r] == cur[r].nw) has[r] = 0;
                    end
                    if (!has[r]) begin
                        if (tq[r].size() > 0) begin
                            cur[r] = tq[r].pop_front(); has[r] = 1; widx[r] = 0;
                        end else if (gen_en && $urandom % 3 == 0) begin
                            cur[r] = rand_txn(); has[r] = 1; widx[r] = 0;
                        end
                    end
                end
                req_valid[r] = has[r] && (!gap_en || $urandom % 4 != 0);
                req_a[r]     = W'(cur[r].a >> (W * widx[r]));
                req_b[r]     = W'(cur[r].b >> (W * widx[r]));
                req_last[r]  = (widx[r] == cur[r].nw - 1);
`ifdef MWORD_ADD_ARBITER_SUB_EN
                req_sub[r]   = (widx[r] == 0) ? cur[r].sub : 1'($urandom);
`endif
            end
        end
    end

    // Reference model: who may go this cycle, and what the accepted word must produce.
    always @(negedge clk) begin
        logic [1:0] er;
        logic       open;
        int         k;
        exp_t       e;
        if (!rst_n) begin
            lock = -1; turn = 0; m_rv = 0; acc = '0;
            sbq.delete();
        end else begin
            chk("rsp_valid", rsp_valid, m_rv);
            open = !m_rv || rsp_ready;
            er   = '0;
            if (lock >= 0)               er[lock] = open;
            else if (req_valid == 2'b11) er[turn] = open;
            else if (req_valid[0])       er[0]    = open;
            else if (req_valid[1])       er[1]    = open;
            chk("ready0", ready0, er[0]);
            chk("ready1", ready1, er[1]);
            acc = req_valid & er;
            k = acc[0] ? 0 : acc[1] ? 1 : -1;
            if (k >= 0) begin
                e      = exp_word(cur[k], widx[k]);
                e.id   = 1'(k);
                e.last = (widx[k] == cur[k].nw - 1);
                sbq.push_back(e);
                if (e.last) begin lock = -1; turn = 1 - k; end
                else        lock = k;
            end
            m_rv = (k >= 0) || (m_rv && !rsp_ready);
        end
    end

    // Monitor: every completed result handshake must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) chk("unexpected_rsp", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("rsp_sum",  rsp_sum,  e.sum);
                chk("rsp_cout", rsp_cout, e.cout);
                chk("rsp_id",   rsp_id,   e.id);
                chk("rsp_last", rsp_last, e.last);
            end
        end
    end

    task automatic drain();
        int n = 0;
        gen_en = 0; gap_en = 0; rdy_mode = 2;
        while ((has[0] || has[1] || tq[0].size() > 0 || tq[1].size() > 0 || sbq.size() > 0 || rsp_valid)
               && n < 500) begin
            @(negedge clk); n++;
        end
        chk("drain_timeout", n < 500, 1);
    endtask

    initial begin
        logic [7:0] cap;
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last}, 0);
        chk("reset_ready", {ready0, ready1}, 0);
        @(negedge clk); #1 rst_n = 1'b1;

        // Single word with carry-out; two-word carry chain on req1.
        tq[0].push_back(mk(1, 'hA, 'h7, 0));
        drain();
        tq[1].push_back(mk(2, 'h0F, 'h01, 0));
        drain();

        // Contention: both present back-to-back multi-word transactions.
        for (int i = 0; i < 3; i++) begin
            tq[0].push_back(mk(2, 'h3C + i, 'hE5, 0));
            tq[1].push_back(mk(3, 'h7FF - i, 'h001, 0));
        end
        drain();

        gen_en = 1; gap_en = 1; rdy_mode = 0;
        repeat (2000) @(posedge clk);

        // Result back-pressure: output must hold and no requester may be taken.
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        rdy_mode = 1;
        @(posedge clk); #2;
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        chk("stall_wait", rsp_valid, 1);
        cap = {rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last};
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", {rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last}, cap);
            chk("stall_ready", {ready0, ready1}, 0);
        end
        rdy_mode = 0;
        repeat (200) @(posedge clk);
        drain();

        // Reset after the first word of a carrying two-word transaction.
        tq[0].push_back(mk(2, 'h0F, 'h01, 0));
        n = 0;
        while (widx[0] != 1 && n < 100) begin @(negedge clk); n++; end
        chk("midtxn_wait", widx[0], 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last}, 0);
        chk("midrst_ready", {ready0, ready1}, 0);
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
        tq[0].push_back(mk(1, 'hA, 'h7, 0));
        drain();

`ifdef MWORD_ADD_ARBITER_SUB_EN
        tq[0].push_back(mk(1, 'h5, 'h7, 1));
        tq[1].push_back(mk(2, 'h12, 'h34, 1));
        drain();
`endif

        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
        $fatal(1);
    end
endmodule
